// File: rtl/sb_tx_serializer_pkg.sv
// Shared definitions for the sideband transmit serializer: default packet and
// gap widths plus the serializer state encoding.
package sb_tx_pkg;

   localparam int SB_PKT_W  = 64;
   localparam int SB_GAP_UI = 32;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } sb_ser_state_e;

   function automatic int sb_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sb_tx_serializer_if.sv
// Packet handshake between the sideband framer (master) and the serializer (slave).
interface sb_tx_serializer_if
   import sb_tx_pkg::*;
#(
   parameter int PKT_W = SB_PKT_W
);

   logic             i_pkt_valid;
   logic [PKT_W-1:0] i_pkt;
   logic             o_pkt_ready;

   modport master (output i_pkt_valid, output i_pkt, input o_pkt_ready);
   modport slave  (input i_pkt_valid, input i_pkt, output o_pkt_ready);

endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: shifts one packet out LSB-first with the clock enable
// high only on data bits, then holds a gated, low idle gap before the next packet.
module sb_tx_serializer
   import sb_tx_pkg::*;
#(
   parameter int PKT_W  = SB_PKT_W,
   parameter int GAP_UI = SB_GAP_UI
) (
   input  logic              i_pll_clk,
   input  logic              i_rst,
   sb_tx_serializer_if.slave pkt_if,
   output logic              o_txdata_sb,
   output logic              o_txclk_en,
   output logic              o_pkt_done,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(sb_max(PKT_W, GAP_UI));
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(PKT_W - 1);
   localparam logic [CNT_W-1:0] DONE_AT    = CNT_W'(PKT_W - 2);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_UI - 1);

   sb_ser_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PKT_W-1:0] shreg_q, shreg_d;
   logic             txdata_q, txdata_d;
   logic             txclk_en_q, txclk_en_d;
   logic             pkt_done_q, pkt_done_d;
   logic             busy_q, busy_d;
   logic             hs;

   assign pkt_if.o_pkt_ready = (state_q == IDLE);
   assign hs                 = pkt_if.i_pkt_valid && (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      txdata_d   = 1'b0;
      txclk_en_d = 1'b0;
      pkt_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Bit 0 goes straight to the output flop so it is on the wire the
            // cycle after the handshake; the register keeps the remaining bits.
            if (hs) begin
               state_d    = SHIFT;
               cnt_d      = '0;
               shreg_d    = pkt_if.i_pkt >> 1;
               txdata_d   = pkt_if.i_pkt[0];
               txclk_en_d = 1'b1;
               pkt_done_d = (PKT_W == 1);
            end
         end
         SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d      = cnt_q + 1'b1;
               txdata_d   = shreg_q[0];
               shreg_d    = shreg_q >> 1;
               txclk_en_d = 1'b1;
               pkt_done_d = (cnt_q == DONE_AT);
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_pll_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         txdata_q   <= 1'b0;
         txclk_en_q <= 1'b0;
         pkt_done_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         txdata_q   <= txdata_d;
         txclk_en_q <= txclk_en_d;
         pkt_done_q <= pkt_done_d;
         busy_q     <= busy_d;
      end
   end

   assign o_txdata_sb = txdata_q;
   assign o_txclk_en  = txclk_en_q;
   assign o_pkt_done  = pkt_done_q;
   assign o_busy      = busy_q;

endmodule
